// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and instruction field positions for the fetch/issue slice
package fetch_pkg;

  localparam int INSTR_W = 32;

  localparam int OP_MSB      = 31;
  localparam int OP_LSB      = 30;
  localparam int RD_MSB      = 29;
  localparam int RD_LSB      = 25;
  localparam int OP3_MSB     = 24;
  localparam int OP3_LSB     = 19;
  localparam int RS1_MSB     = 18;
  localparam int RS1_LSB     = 14;
  localparam int IMM_SEL_MSB = 13;
  localparam int IMM_SEL_LSB = 13;
  localparam int SIMM13_MSB  = 12;
  localparam int SIMM13_LSB  = 0;
  localparam int RS2_MSB     = 4;
  localparam int RS2_LSB     = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_ISSUE
  } fetch_state_t;

endpackage

// File: rtl/fetch_issue_if.sv
// rtl/fetch_issue_if.sv - instruction-memory and issue/redirect signals of the fetch stage
interface fetch_issue_if;
  import fetch_pkg::*;

  logic                            imem_req;
  logic [31:0]                     imem_addr;
  logic                            imem_rvalid;
  logic [INSTR_W-1:0]              imem_rdata;
  logic                            issue_valid;
  logic                            issue_ready;
  logic [OP_MSB-OP_LSB:0]          op;
  logic [OP3_MSB-OP3_LSB:0]        op3;
  logic [RD_MSB-RD_LSB:0]          rd;
  logic [RS1_MSB-RS1_LSB:0]        rs1;
  logic [RS2_MSB-RS2_LSB:0]        rs2;
  logic                            imm_sel;
  logic [SIMM13_MSB-SIMM13_LSB:0]  simm13;
  logic [31:0]                     pc_out;
  logic                            branch_taken;
  logic [31:0]                     branch_target;

  modport master (
    output imem_req, imem_addr, issue_valid,
    output op, op3, rd, rs1, rs2, imm_sel, simm13, pc_out,
    input  imem_rvalid, imem_rdata, issue_ready, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, issue_valid,
    input  op, op3, rd, rs1, rs2, imm_sel, simm13, pc_out,
    output imem_rvalid, imem_rdata, issue_ready, branch_taken, branch_target
  );

endinterface

// File: rtl/instr_split.sv
// rtl/instr_split.sv - combinational split of an instruction word into decode fields
module instr_split
  import fetch_pkg::*;
(
  input  logic [INSTR_W-1:0]             instr,
  output logic [OP_MSB-OP_LSB:0]         op,
  output logic [OP3_MSB-OP3_LSB:0]       op3,
  output logic [RD_MSB-RD_LSB:0]         rd,
  output logic [RS1_MSB-RS1_LSB:0]       rs1,
  output logic [RS2_MSB-RS2_LSB:0]       rs2,
  output logic                           imm_sel,
  output logic [SIMM13_MSB-SIMM13_LSB:0] simm13
);

  assign op      = instr[OP_MSB:OP_LSB];
  assign op3     = instr[OP3_MSB:OP3_LSB];
  assign rd      = instr[RD_MSB:RD_LSB];
  assign rs1     = instr[RS1_MSB:RS1_LSB];
  assign rs2     = instr[RS2_MSB:RS2_LSB];
  assign imm_sel = instr[IMM_SEL_MSB];
  assign simm13  = instr[SIMM13_MSB:SIMM13_LSB];

endmodule

// File: rtl/fetch_issue.sv
// rtl/fetch_issue.sv - fetch/issue stage with SPARC delayed branch; FETCH_ISSUE_ALIGN_CHK_EN adds misaligned-target trap
module fetch_issue
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_issue_if.master bus
`ifdef FETCH_ISSUE_ALIGN_CHK_EN
  ,
  output logic          misalign_trap
`endif
);

  fetch_state_t       state, state_nxt;
  logic [31:0]        pc, npc;
  logic [INSTR_W-1:0] ir;
  logic               issuing;
  logic               handshake;

  assign issuing   = (state == ST_ISSUE);
  assign handshake = issuing && bus.issue_ready;

`ifdef FETCH_ISSUE_ALIGN_CHK_EN
  logic trap_q;
  logic misaligned;
  assign misaligned    = handshake && bus.branch_taken && (bus.branch_target[1:0] != 2'b00);
  assign misalign_trap = trap_q;
`else
  logic unused_tgt_bits;
  assign unused_tgt_bits = &{1'b0, bus.branch_target[1:0]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
      npc   <= RESET_PC + PC_STEP;
      ir    <= '0;
`ifdef FETCH_ISSUE_ALIGN_CHK_EN
      trap_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == ST_WAIT && bus.imem_rvalid) begin
        ir <= bus.imem_rdata;
      end
      // Delayed branch: the old nPC always issues next; the target only reaches nPC.
      if (handshake) begin
        pc  <= npc;
        npc <= bus.branch_taken ? {bus.branch_target[31:2], 2'b00} : npc + PC_STEP;
      end
`ifdef FETCH_ISSUE_ALIGN_CHK_EN
      if (misaligned) begin
        trap_q <= 1'b1;
      end
`endif
    end
  end

  always_comb begin
    state_nxt       = state;
    bus.imem_req    = 1'b0;
    bus.imem_addr   = '0;
    bus.issue_valid = 1'b0;
    case (state)
      ST_IDLE: begin
`ifdef FETCH_ISSUE_ALIGN_CHK_EN
        if (!trap_q) state_nxt = ST_FETCH;
`else
        state_nxt = ST_FETCH;
`endif
      end
      ST_FETCH: begin
        bus.imem_req  = 1'b1;
        bus.imem_addr = pc;
        state_nxt     = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.imem_rvalid) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        bus.issue_valid = 1'b1;
        if (bus.issue_ready) begin
`ifdef FETCH_ISSUE_ALIGN_CHK_EN
          state_nxt = misaligned ? ST_IDLE : ST_FETCH;
`else
          state_nxt = ST_FETCH;
`endif
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Fields read as zero outside ISSUE even though ir keeps the last word.
  instr_split u_split (
    .instr   (issuing ? ir : '0),
    .op      (bus.op),
    .op3     (bus.op3),
    .rd      (bus.rd),
    .rs1     (bus.rs1),
    .rs2     (bus.rs2),
    .imm_sel (bus.imm_sel),
    .simm13  (bus.simm13)
  );

  assign bus.pc_out = issuing ? pc : '0;

endmodule

// File: tb/tb_fetch_issue.sv
// tb/tb_fetch_issue.sv - randomized self-checking bench for fetch_issue against an architectural PC/nPC model
module tb_fetch_issue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_issue_if bus();
`ifdef FETCH_ISSUE_ALIGN_CHK_EN
  logic misalign_trap;
`endif

  fetch_issue #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_ISSUE_ALIGN_CHK_EN
    ,
    .misalign_trap (misalign_trap)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h8600_4002;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // architectural model and environment state
  int          cyc = 0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_npc = 32'h4;
  int          req_expect = -1;
  int          issue_expect = -1;
  bit          exp_valid = 0;
  bit          m_trap = 0;
  bit          rst_drive = 1;
  bit          rst_was = 1;
  int          rel_cycle = 0;
  int          first_issue_cycle = -1;
  bit          chk038 = 0;
  bit          pend = 0;
  int          due = 0;
  logic [31:0] pend_addr = 32'h0;
  int          lat = 1;
  bit          rand_lat = 0;
  bit          flush_on_rst = 0;
  int          rdy_pct = 100;
  bit          force_stall = 0;
  int          br_mode = 0;
  logic [31:0] br_pc = 32'h0;
  logic [31:0] br_tgt = 32'h0;
  int          req_count = 0;
  logic [31:0] issued[$];
  logic [31:0] addr_log[$];

  task automatic step();
    logic [31:0] w;
    bit          rdy, tk, hs, rst_q;
    logic [31:0] tg;
    @(posedge clk);
    #1;
    cyc++;
    rst_q = rst;
    if (issue_expect == cyc) exp_valid = 1;
    check("issue_valid", bus.issue_valid, exp_valid);
    check("imem_req", bus.imem_req, req_expect == cyc);
`ifdef FETCH_ISSUE_ALIGN_CHK_EN
    check("misalign_trap", misalign_trap, m_trap);
`endif
    if (bus.issue_valid && first_issue_cycle < 0) first_issue_cycle = cyc - rel_cycle;
    if (exp_valid) begin
      w = mem_word(m_pc);
      check("pc_out", bus.pc_out, m_pc);
      check("op", bus.op, w[31:30]);
      check("rd", bus.rd, w[29:25]);
      check("op3", bus.op3, w[24:19]);
      check("rs1", bus.rs1, w[18:14]);
      check("imm_sel", bus.imm_sel, w[13]);
      check("simm13", bus.simm13, w[12:0]);
      check("rs2", bus.rs2, w[4:0]);
      if (chk038 && m_pc == 32'h0) begin
        chk038 = 0;
        check("r038_op", bus.op, 2'b10);
        check("r038_rd", bus.rd, 5'd3);
        check("r038_op3", bus.op3, 6'h00);
        check("r038_rs1", bus.rs1, 5'd1);
        check("r038_imm_sel", bus.imm_sel, 1'b0);
        check("r038_rs2", bus.rs2, 5'd2);
      end
    end else begin
      check("fields_idle_zero", {bus.op, bus.op3, bus.rd, bus.rs1, bus.rs2, bus.imm_sel, bus.simm13}, 0);
    end
    if (rst_q) check("pc_out_reset", bus.pc_out, 32'h0);
    if (bus.imem_req) begin
      req_count++;
      check("imem_addr", bus.imem_addr, m_pc);
      addr_log.push_back(bus.imem_addr);
    end
    // memory side
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom;
    if (pend && cyc == due) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(pend_addr);
      pend = 0;
    end
    if (bus.imem_req) begin
      pend      = 1;
      pend_addr = bus.imem_addr;
      due       = cyc + (rand_lat ? int'($urandom_range(3, 1)) : lat);
      issue_expect = due + 1;
    end else if (!pend && !bus.imem_rvalid && $urandom_range(3) == 0) begin
      bus.imem_rvalid = 1'b1;
    end
    // issue side
    rdy = force_stall ? 1'b0 : ($urandom_range(99) < rdy_pct);
    tg  = $urandom;
    tk  = exp_valid ? 1'b0 : 1'($urandom_range(1));
    if (exp_valid) begin
      case (br_mode)
        1: if (m_pc == br_pc) begin tk = 1; tg = br_tgt; end
        2: begin
          tk = ($urandom_range(3) == 0);
`ifdef FETCH_ISSUE_ALIGN_CHK_EN
          tg[1:0] = 2'b00;
`endif
        end
        3: begin tk = 1; tg = br_tgt; end
        default: ;
      endcase
    end
    bus.issue_ready   = rdy;
    bus.branch_taken  = tk;
    bus.branch_target = tg;
    hs = exp_valid && rdy;
    if (rst_drive) begin
      m_pc = 32'h0; m_npc = 32'h4;
      exp_valid = 0; req_expect = -1; issue_expect = -1; m_trap = 0;
      rst_was = 1;
      if (flush_on_rst) pend = 0;
    end else begin
      if (rst_was) begin
        req_expect = cyc + 1;
        rel_cycle  = cyc;
        rst_was    = 0;
      end
      if (hs) begin
        issued.push_back(m_pc);
        exp_valid = 0;
        if (br_mode == 3) br_mode = 0;
`ifdef FETCH_ISSUE_ALIGN_CHK_EN
        if (tk && tg[1:0] != 2'b00) begin
          m_trap = 1;
          req_expect = -1;
        end else begin
          req_expect = cyc + 1;
        end
`else
        req_expect = cyc + 1;
`endif
        m_pc  = m_npc;
        m_npc = tk ? {tg[31:2], 2'b00} : m_npc + 32'd4;
      end
    end
    rst = rst_drive;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          found;
    logic [31:0] after;
    bus.imem_rvalid   = 1'b0;
    bus.imem_rdata    = '0;
    bus.issue_ready   = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;

    rst_drive = 1;
    repeat (3) step();

    // reset release, sequential fetch, delayed branch at PC=8 to 0x40
    rst_drive = 0; chk038 = 1; first_issue_cycle = -1;
    br_mode = 1; br_pc = 32'h8; br_tgt = 32'h40;
    issued.delete(); addr_log.delete();
    for (int i = 0; i < 100 && issued.size() < 6; i++) step();
    check("phaseA_issues", issued.size() >= 6, 1);
    check("first_issue_cycle", first_issue_cycle, 3);
    if (addr_log.size() >= 3) begin
      check("addr0", addr_log[0], 32'h0);
      check("addr1", addr_log[1], 32'h4);
      check("addr2", addr_log[2], 32'h8);
    end
    if (issued.size() >= 6) begin
      check("br_seq3", issued[3], 32'hC);
      check("br_seq4", issued[4], 32'h40);
      check("br_seq5", issued[5], 32'h44);
    end
    check("r038_seen", chk038, 0);
    br_mode = 0;

    // hold issue_ready low for 5 cycles
    force_stall = 1;
    for (int i = 0; i < 20 && !exp_valid; i++) step();
    check("stall_reached", exp_valid, 1);
    req_count = 0;
    repeat (5) step();
    check("stall_no_req", req_count, 0);
    force_stall = 0;
    repeat (6) step();

    // branch to the top of the address space, wrapping to 0
    br_mode = 3; br_tgt = 32'hFFFF_FFFC;
    issued.delete();
    repeat (30) step();
    found = 0; after = '1;
    for (int k = 0; k + 1 < issued.size(); k++)
      if (issued[k] == 32'hFFFF_FFFC) begin found = 1; after = issued[k + 1]; end
    check("wrap_seen", found, 1);
    check("wrap_next", after, 32'h0);

    // reset during WAIT, late rvalid must be ignored
    lat = 3;
    for (int i = 0; i < 20 && !(pend && due > cyc); i++) step();
    check("wait_reached", pend, 1);
    rst_drive = 1;
    step();
    rst_drive = 0;
    addr_log.delete();
    repeat (12) step();
    check("post_rst_addr", addr_log.size() > 0 ? addr_log[0] : 32'hDEAD_BEEF, 32'h0);
    lat = 1;

    // randomized traffic with random latency, backpressure, branches and resets
    rand_lat = 1; flush_on_rst = 1; rdy_pct = 60; br_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      rst_drive = ($urandom_range(299) == 0);
      step();
    end
    rst_drive = 0; br_mode = 0; rdy_pct = 100; rand_lat = 0;
    repeat (10) step();

`ifdef FETCH_ISSUE_ALIGN_CHK_EN
    // misaligned taken target traps and stops fetching until reset
    br_mode = 3; br_tgt = 32'h42;
    for (int i = 0; i < 30 && !m_trap; i++) step();
    check("trap_model_set", m_trap, 1);
    req_count = 0;
    repeat (12) step();
    check("trap_no_req", req_count, 0);
    check("trap_held", misalign_trap, 1);
    rst_drive = 1;
    repeat (2) step();
    rst_drive = 0;
    repeat (8) step();
    check("trap_cleared", misalign_trap, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
